// File: rtl/edge_period_meter_if.sv
// Measurement bus of the edge period meter: the signal under test going in,
// the period / high-time results and status coming out.
interface edge_period_meter_if #(
  parameter int WIDTH = 32
);
  logic             sig_in;
  logic [WIDTH-1:0] period;
  logic [WIDTH-1:0] high_time;
  logic             valid;
  logic             timeout;
  logic [15:0]      meas_count;

  // Side that drives the input signal and consumes measurements
  modport master (
    output sig_in,
    input  period, high_time, valid, timeout, meas_count
  );

  // The meter itself
  modport slave (
    input  sig_in,
    output period, high_time, valid, timeout, meas_count
  );
endinterface

// File: rtl/edge_period_meter.sv
// Edge period meter: synchronises a slow asynchronous square wave, detects its
// edges and reports rise-to-rise period and rise-to-fall high time in clk
// cycles, one result per input cycle, plus a timeout flag for a stopped input.
module edge_period_meter #(
  parameter int          WIDTH   = 32,
  parameter int unsigned TIMEOUT = 200_000_000
) (
  input  logic               clk,
  input  logic               rst,
  edge_period_meter_if.slave bus
);

  localparam logic [WIDTH-1:0] TMAX = WIDTH'(TIMEOUT);
  localparam logic [WIDTH-1:0] ONE  = WIDTH'(1);

  typedef enum logic {
    IDLE,
    MEAS
  } state_t;

  logic             s1, s2, d;
  logic             rise, fall;
  logic [WIDTH-1:0] cnt, hcnt, hi_cap;
  state_t           state;
  logic [WIDTH-1:0] period_r, high_time_r;
  logic             valid_r, timeout_r;
  logic [15:0]      meas_count_r;

  // Two-flop synchroniser followed by a delay flop for edge detection
  always_ff @(posedge clk) begin
    if (rst) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      d  <= 1'b0;
    end else begin
      s1 <= bus.sig_in;
      s2 <= s1;
      d  <= s2;
    end
  end

  assign rise = s2 & ~d;
  assign fall = ~s2 & d;

  // Cycle counters: reload on rise, saturate at TIMEOUT; hcnt freezes on fall
  // and its value at the fall is the high time of the current cycle
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt    <= '0;
      hcnt   <= '0;
      hi_cap <= '0;
    end else begin
      if (rise)
        cnt <= ONE;
      else if (cnt < TMAX)
        cnt <= cnt + ONE;

      if (rise)
        hcnt <= ONE;
      else if (!fall && hcnt < TMAX)
        hcnt <= hcnt + ONE;

      if (fall)
        hi_cap <= hcnt;
    end
  end

  // Measurement FSM with registered outputs; a rise coinciding with the
  // saturation point still counts as a measurement of exactly TIMEOUT
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      period_r     <= '0;
      high_time_r  <= '0;
      valid_r      <= 1'b0;
      timeout_r    <= 1'b0;
      meas_count_r <= '0;
    end else begin
      valid_r <= 1'b0;
      case (state)
        IDLE: begin
          if (rise) begin
            state     <= MEAS;
            timeout_r <= 1'b0;
          end else if (cnt == TMAX) begin
            timeout_r <= 1'b1;
          end
        end
        MEAS: begin
          if (rise) begin
            period_r     <= cnt;
            high_time_r  <= hi_cap;
            valid_r      <= 1'b1;
            meas_count_r <= meas_count_r + 16'd1;
            timeout_r    <= 1'b0;
          end else if (cnt == TMAX) begin
            state     <= IDLE;
            timeout_r <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.period     = period_r;
  assign bus.high_time  = high_time_r;
  assign bus.valid      = valid_r;
  assign bus.timeout    = timeout_r;
  assign bus.meas_count = meas_count_r;

endmodule

// File: tb/tb_edge_period_meter.sv
// Bench for edge_period_meter: directed square-wave stimulus with expected
// measurements queued at the rise that completes them; a monitor pops and
// compares on every valid pulse.
`timescale 1ns/1ps
module tb_edge_period_meter;

  localparam int WIDTH   = 16;
  localparam int TIMEOUT = 1000;

  logic clk;
  logic rst;

  edge_period_meter_if #(.WIDTH(WIDTH)) bus();

  edge_period_meter #(.WIDTH(WIDTH), .TIMEOUT(TIMEOUT)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    int p_lo;
    int p_hi;
    int h_lo;
    int h_hi;
    int meas;
    int gap;
    bit async_m;
  } exp_t;

  exp_t q[$];
  exp_t e;
  int   n_tests = 0;
  int   n_fail  = 0;
  int   cyc     = 0;
  int   last_vcyc = 0;
  int   async_sum = 0;
  bit   saw_to = 1'b0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic check_rng(input string name, input int act, input int lo, input int hi);
    n_tests++;
    if (act < lo || act > hi) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d..%0d", name, act, lo, hi);
    end
  endtask

  task automatic expect_exact(input int p, input int h, input int m, input int gap);
    exp_t x;
    x.p_lo = p; x.p_hi = p; x.h_lo = h; x.h_hi = h;
    x.meas = m; x.gap = gap; x.async_m = 1'b0;
    q.push_back(x);
  endtask

  task automatic expect_async(input int m);
    exp_t x;
    x.p_lo = 36; x.p_hi = 38; x.h_lo = 14; x.h_hi = 16;
    x.meas = m; x.gap = 0; x.async_m = 1'b1;
    q.push_back(x);
  endtask

  // Monitor: compare every valid against the next queued expectation
  always @(negedge clk) begin
    if (bus.timeout) saw_to = 1'b1;
    if (bus.valid) begin
      if (q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected_valid: period=%0d high_time=%0d, no measurement expected",
                 bus.period, bus.high_time);
      end else begin
        e = q.pop_front();
        check_rng("period", int'(bus.period), e.p_lo, e.p_hi);
        check_rng("high_time", int'(bus.high_time), e.h_lo, e.h_hi);
        check("meas_count", int'(bus.meas_count), e.meas);
        if (e.gap != 0) check("valid_gap", cyc - last_vcyc, e.gap);
        if (e.async_m) async_sum += int'(bus.period);
      end
      last_vcyc = cyc;
    end
  end

  task automatic wait_cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    wait_cyc(3);
    rst = 1'b0;
  endtask

  task automatic pulse(input int h, input int l);
    bus.sig_in = 1'b1;
    wait_cyc(h);
    bus.sig_in = 1'b0;
    wait_cyc(l);
  endtask

  task automatic drain(input string name);
    int n;
    n = 0;
    while (q.size() != 0 && n < 50) begin
      wait_cyc(1);
      n++;
    end
    check({name, "_drain_pending"}, q.size(), 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int t0;
    int j;
    rst = 1'b1;
    bus.sig_in = 1'b0;
    wait_cyc(1);

    // Reset state
    do_reset();
    wait_cyc(1);
    check("rst_period", int'(bus.period), 0);
    check("rst_high_time", int'(bus.high_time), 0);
    check("rst_valid", int'(bus.valid), 0);
    check("rst_timeout", int'(bus.timeout), 0);
    check("rst_meas_count", int'(bus.meas_count), 0);

    // 1: square wave P=10 H=3, five periods
    do_reset();
    wait_cyc(2);
    pulse(3, 7);
    for (int i = 1; i <= 4; i++) begin
      expect_exact(10, 3, i, (i == 1) ? 0 : 10);
      pulse(3, 7);
    end
    drain("sq");
    check("sq_meas_count", int'(bus.meas_count), 4);
    check("sq_timeout", int'(bus.timeout), 0);

    // 2: extremes P=4/H=2 then P=1000/H=999
    do_reset();
    wait_cyc(2);
    saw_to = 1'b0;
    pulse(2, 2);
    expect_exact(4, 2, 1, 0);
    pulse(2, 2);
    expect_exact(4, 2, 2, 0);
    pulse(2, 2);
    expect_exact(4, 2, 3, 0);
    pulse(999, 1);
    expect_exact(1000, 999, 4, 0);
    pulse(999, 1);
    expect_exact(1000, 999, 5, 0);
    pulse(2, 2);
    drain("ext");
    check("ext_no_timeout", int'(saw_to), 0);
    check("ext_meas_count", int'(bus.meas_count), 5);

    // 3: stopped input, timeout exactly 1000 cycles after the last rise
    do_reset();
    wait_cyc(2);
    pulse(3, 7);
    expect_exact(10, 3, 1, 0);
    pulse(3, 7);
    drain("stop");
    wait_cyc(992);
    check("stop_timeout_early", int'(bus.timeout), 0);
    wait_cyc(1);
    check("stop_timeout_set", int'(bus.timeout), 1);
    check("stop_period_held", int'(bus.period), 10);
    check("stop_high_held", int'(bus.high_time), 3);
    bus.sig_in = 1'b1;
    wait_cyc(4);
    check("stop_timeout_clear", int'(bus.timeout), 0);
    wait_cyc(1);
    bus.sig_in = 1'b0;
    wait_cyc(15);
    expect_exact(20, 5, 2, 0);
    pulse(5, 5);
    drain("restart");
    check("restart_meas_count", int'(bus.meas_count), 2);

    // 4: input stuck high through reset release
    bus.sig_in = 1'b1;
    do_reset();
    wait_cyc(1002);
    check("stuck_timeout_early", int'(bus.timeout), 0);
    wait_cyc(1);
    check("stuck_timeout_set", int'(bus.timeout), 1);
    check("stuck_meas_count", int'(bus.meas_count), 0);
    check("stuck_period", int'(bus.period), 0);
    bus.sig_in = 1'b0;
    wait_cyc(5);

    // 5: reset mid-measurement in a P=50 stream
    do_reset();
    wait_cyc(2);
    pulse(20, 30);
    expect_exact(50, 20, 1, 0);
    bus.sig_in = 1'b1;
    wait_cyc(20);
    bus.sig_in = 1'b0;
    wait_cyc(10);
    drain("mid");
    rst = 1'b1;
    wait_cyc(1);
    check("mid_rst_period", int'(bus.period), 0);
    check("mid_rst_high_time", int'(bus.high_time), 0);
    check("mid_rst_valid", int'(bus.valid), 0);
    check("mid_rst_timeout", int'(bus.timeout), 0);
    check("mid_rst_meas_count", int'(bus.meas_count), 0);
    rst = 1'b0;
    wait_cyc(19);
    pulse(20, 30);
    expect_exact(50, 20, 1, 0);
    pulse(20, 30);
    drain("mid_after");
    check("mid_meas_restart", int'(bus.meas_count), 1);

    // 6: asynchronous edges, P=37 H=15, sub-cycle jitter on every edge
    do_reset();
    wait_cyc(2);
    async_sum = 0;
    t0 = int'($time);
    for (int i = 0; i <= 100; i++) begin
      if (i > 0) expect_async(i);
      j = int'($urandom_range(0, 8));
      #(t0 + 370 * i + j - int'($time));
      bus.sig_in = 1'b1;
      j = int'($urandom_range(0, 8));
      #(t0 + 370 * i + 150 + j - int'($time));
      bus.sig_in = 1'b0;
    end
    wait_cyc(5);
    drain("async");
    check("async_meas_count", int'(bus.meas_count), 100);
    check_rng("async_period_sum", async_sum, 3695, 3705);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/edge_period_meter.md
# edge_period_meter

Measures the period and high time of a slow, asynchronous square wave (for example, a divided clock or an external pulse train) in units of the system clock. It synchronises the input, detects rising and falling edges, and counts `clk` cycles between them. It publishes one `period`/`high_time` pair per input cycle, with a one-cycle `valid` strobe. It is the receiving end of the lab's slow-clock generation path: a board-level check that a generated or external slow clock has the intended frequency and duty cycle.

## Interface
- `WIDTH`, 32: width of the cycle counter and of the `period`/`high_time` outputs.
- `TIMEOUT`, 200_000_000: longest measurable period in `clk` cycles. Must satisfy 2 ≤ `TIMEOUT` < 2^`WIDTH`.

- `clk`  in  1  system clock; all logic on its rising edge.
- `rst`  in  1  reset: synchronous, active-high.
- `sig_in`  in  1  asynchronous signal under measurement.
- `period`  out  WIDTH  last measured rise-to-rise interval, in cycles.
- `high_time`  out  WIDTH  last measured rise-to-fall interval, in cycles.
- `valid`  out  1  one-cycle pulse when `period`/`high_time` update.
- `timeout`  out  1  level; the input has had no rising edge for `TIMEOUT` cycles.
- `meas_count`  out  16  number of `valid` pulses since reset; wraps 0xFFFF→0.

## Operation
- **Input synchroniser:** two flops, `s1` then `s2`, followed by a delay flop `d`. All three reset to 0.
  - `rise` = `s2 & ~d`.
  - `fall` = `~s2 & d`.
  - All decisions below are taken at the clock edge where `rise` or `fall` is high.
- **Counters:**
  - `cnt` is reloaded to 1 on each `rise`. Otherwise it increments and saturates at `TIMEOUT`.
  - `hcnt` counts the same way but is frozen on `fall`.
  - On `fall`, `hcnt` is captured into internal register `hi_cap`.
- **FSM, IDLE** (reset state):
  - On `rise`: go to MEAS. Load `cnt` and `hcnt` to 1. Clear `timeout`. No `valid`.
  - No `rise` and `cnt` == `TIMEOUT`: set `timeout`=1 and stay in IDLE.
- **FSM, MEAS:**
  - On `rise`: `period`←`cnt`, `high_time`←`hi_cap`, `valid`=1, `meas_count`++, `timeout`←0. Reload counters. Stay in MEAS.
  - No `rise` and `cnt` == `TIMEOUT`: go to IDLE and set `timeout`=1. `period`, `high_time` and `meas_count` hold their last values.
- **Simultaneous `rise` and `cnt` == `TIMEOUT`:** the rise wins. `period`=`TIMEOUT` is a legal measurement.
- **Spurious edges:** a `rise` at reset release (`sig_in` already high) only arms IDLE→MEAS and never produces `valid`.
- **Saturation:** counters never wrap. Arithmetic is unsigned, `WIDTH` bits.
- **`high_time` when no `fall` occurred between two rises** (impossible after synchronisation, but defined anyway): `hi_cap` holds its previous value.

## Timing
- **Reset values:** `period`=0, `high_time`=0, `valid`=0, `timeout`=0, `meas_count`=0. FSM=IDLE, counters=0, `hi_cap`=0.
- **`rst` mid-measurement:** all of the above are restored on the same edge. The partial measurement is discarded.
- **Latency:** a `sig_in` transition meeting setup before edge k is seen as `rise`/`fall` at edge k+2. `valid` is registered and high during the cycle after edge k+2.
- **Measurement definition:** a square wave with period P cycles and high time H cycles (1 ≤ H < P ≤ `TIMEOUT`) gives `period`=P and `high_time`=H exactly. Synchroniser delay cancels out.
- **Output update:** `period`/`high_time` change only together with `valid` and are stable between pulses.
- **First measurement:** available on the second rising edge after reset.
- **Timeout timing:** `timeout` rises at the edge where `cnt` reaches `TIMEOUT` without a rise, i.e. `TIMEOUT` cycles after the last rise. It falls at the next `rise`.
- **Input constraints:**
  - High and low phases must each last ≥ 2 cycles to be resolved.
  - Shorter glitches may be lost; this is not an error condition.

## Test plan
Bench uses `TIMEOUT`=1000 and `WIDTH`=16.

1. **Square wave:** reset, then drive `sig_in` with P=10, H=3 for 5 periods. Expect:
   - no `valid` on the first rise;
   - then 4 `valid` pulses spaced exactly 10 cycles apart, each with `period`=10, `high_time`=3;
   - `meas_count`=4 and `timeout`=0.
2. **Extremes:** P=4/H=2, then P=1000/H=999. Expect `period`=4/`high_time`=2, then `period`=1000/`high_time`=999 with `timeout` never asserting.
3. **Stopped input:** after a valid measurement, hold `sig_in` low. Expect:
   - `timeout`=1 exactly 1000 cycles after the last rise, with `period` held;
   - the FSM in IDLE;
   - the next two rises 20 cycles apart → `timeout` clears at the first rise, `valid` with `period`=20 at the second.
4. **Stuck high through reset:** hold `sig_in`=1 through reset release. Expect a `rise` with no `valid`, then `timeout`=1 after 1000 cycles.
5. **Reset mid-measurement:** pulse `rst` mid-period during a P=50 stream. Expect all outputs 0 on the next edge, the next `valid` only after two subsequent rises, and `meas_count` restarting at 1.
6. **Asynchronous input:** drive `sig_in` with edges offset by random sub-cycle delays, P=37. Expect every `period` ∈ {36, 37, 38}, and the average over 100 measurements within ±0.05 of 37.
